// File: rtl/wishbone_pkg.sv
// Shared definitions for the Wishbone interconnect demonstrator.
//   - master FSM state encoding
//   - slave-select codes on ADR[7:6]
//   - slave register-file depth and default bus widths
package wishbone_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mst_state_e;

  localparam logic [1:0] SLV0_SEL   = 2'b10;
  localparam logic [1:0] SLV1_SEL   = 2'b11;
  localparam int         SLV_DEPTH  = 16;
  localparam int         DEF_DATA_W = 64;
  localparam int         DEF_ADR_W  = 8;

endpackage

// File: rtl/wb_slave_regfile.sv
// Wishbone classic register-file slave, SLV_DEPTH words of DATA_W bits.
// Ports:
//   clk, rst        clock, async active-high reset
//   cyc, stb, we    bus cycle qualifiers from the master
//   sel             address-decode select for this slave
//   adr             word index within the slave
//   dat_i           write data
//   ack             registered, single-cycle acknowledge
//   dat_o           registered read data
module wb_slave_regfile
  import wishbone_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cyc,
  input  logic                         stb,
  input  logic                         we,
  input  logic                         sel,
  input  logic [$clog2(SLV_DEPTH)-1:0] adr,
  input  logic [DATA_W-1:0]            dat_i,
  output logic                         ack,
  output logic [DATA_W-1:0]            dat_o
);

  logic [SLV_DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DATA_W-1:0]                dat_q, dat_d;
  logic                             ack_q, ack_d;
  logic                             hit;

  // ~ack_q keeps the ack one cycle wide even though STB is still high
  // on the edge where the master consumes it.
  always_comb begin
    hit   = cyc & stb & sel & ~ack_q;
    ack_d = hit;
    mem_d = mem_q;
    dat_d = dat_q;
    if (hit) begin
      if (we) mem_d[adr] = dat_i;
      else    dat_d      = mem_q[adr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      dat_q <= '0;
      ack_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      dat_q <= dat_d;
      ack_q <= ack_d;
    end
  end

  assign ack   = ack_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/wishbone_intercon.sv
// Self-contained Wishbone B4 classic system: one master FSM turning
// side-band requests into single bus cycles, an address decoder, two
// register-file slaves and a default responder for unmapped addresses.
// Ports:
//   CLK_I, RST_I   clock, async active-high reset
//   DATA_INPUT     write data for the next cycle
//   ADR_INPUT      word address for the next cycle
//   WE_INPUT       request a write (wins over SMP)
//   SMP            request a read when WE_INPUT=0
//   DATA_OUTPUT    last read data, registered
module wishbone_intercon
  import wishbone_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADR_W  = DEF_ADR_W
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [DATA_W-1:0] DATA_INPUT,
  input  logic [ADR_W-1:0]  ADR_INPUT,
  input  logic              WE_INPUT,
  input  logic              SMP,
  output logic [DATA_W-1:0] DATA_OUTPUT
);

  localparam int NUM_SLV = 2;

  mst_state_e        state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              def_ack_q, def_ack_d;

  logic [NUM_SLV-1:0]             slv_sel, slv_ack;
  logic [NUM_SLV-1:0][DATA_W-1:0] slv_dat;
  logic                           def_sel;
  logic                           bus_ack;
  logic [DATA_W-1:0]              bus_dat;

  // Only ADR[7:6] selects and ADR[3:0] indexes; the rest is don't-care.
  logic unused_adr;
  assign unused_adr = ^adr_q;

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_slv
    assign slv_sel[g] = (adr_q[7:6] == ((g == 0) ? SLV0_SEL : SLV1_SEL));

    wb_slave_regfile #(.DATA_W(DATA_W)) u_slv (
      .clk   (CLK_I),
      .rst   (RST_I),
      .cyc   (cyc_q),
      .stb   (stb_q),
      .we    (we_q),
      .sel   (slv_sel[g]),
      .adr   (adr_q[3:0]),
      .dat_i (dat_q),
      .ack   (slv_ack[g]),
      .dat_o (slv_dat[g])
    );
  end

  assign def_sel = ~|slv_sel;

  // Default responder: same ack timing as a slave so the bus never hangs;
  // writes are dropped and reads see zero through the mux.
  assign def_ack_d = cyc_q & stb_q & def_sel & ~def_ack_q;

  assign bus_ack = |(slv_ack & slv_sel) | (def_ack_q & def_sel);
  assign bus_dat = slv_sel[0] ? slv_dat[0] :
                   slv_sel[1] ? slv_dat[1] : '0;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (WE_INPUT || SMP) begin
          we_d    = WE_INPUT;
          adr_d   = ADR_INPUT;
          dat_d   = DATA_INPUT;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus_ack) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = IDLE;
          if (!we_q) dout_d = bus_dat;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      dout_q    <= '0;
      def_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      dout_q    <= dout_d;
      def_ack_q <= def_ack_d;
    end
  end

  assign DATA_OUTPUT = dout_q;

endmodule

// File: tb/tb_wishbone_intercon.sv
module tb_wishbone_intercon;

  localparam int DATA_W = 64;
  localparam int ADR_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] din;
  logic [ADR_W-1:0]  adr;
  logic              we;
  logic              smp;
  logic [DATA_W-1:0] dout;

  int checks   = 0;
  int failures = 0;

  // Reference model: two 16-word stores plus the last read value.
  logic [DATA_W-1:0] mem_m [2][16];
  logic [DATA_W-1:0] dout_m;

  wishbone_intercon #(.DATA_W(DATA_W), .ADR_W(ADR_W)) dut (
    .CLK_I       (clk),
    .RST_I       (rst),
    .DATA_INPUT  (din),
    .ADR_INPUT   (adr),
    .WE_INPUT    (we),
    .SMP         (smp),
    .DATA_OUTPUT (dout)
  );

  always #5 clk = ~clk;

  function automatic logic mapped(input logic [7:0] a);
    return a[7];
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++) mem_m[s][w] = '0;
    dout_m = '0;
  endtask

  task automatic model_txn(input logic w, input logic [7:0] a, input logic [DATA_W-1:0] d);
    if (w) begin
      if (mapped(a)) mem_m[a[6]][a[3:0]] = d;
    end else begin
      dout_m = mapped(a) ? mem_m[a[6]][a[3:0]] : '0;
    end
  endtask

  // One request starting at a falling edge with the master idle; request is
  // dropped after the sampling edge. Ends at the falling edge after edge 3.
  task automatic do_txn(input logic w, input logic s, input logic [7:0] a,
                        input logic [DATA_W-1:0] d, input string name);
    we = w; smp = s; adr = a; din = d;
    @(negedge clk);
    we = 1'b0; smp = 1'b0;
    checks++;
    if (dut.stb_q !== 1'b1) begin
      failures++; $display("FAIL %s stb_edge1 got=%b want=1", name, dut.stb_q);
    end
    @(negedge clk);
    checks++;
    if (dut.bus_ack !== 1'b1) begin
      failures++; $display("FAIL %s ack_edge2 got=%b want=1", name, dut.bus_ack);
    end
    @(negedge clk);
    model_txn(w, a, d);
    checks++;
    if (dut.stb_q !== 1'b0 || dout !== dout_m) begin
      failures++;
      $display("FAIL %s dout got=%h want=%h stb=%b", name, dout, dout_m, dut.stb_q);
    end
  endtask

  task automatic test_reset();
    int acks = 0;
    rst = 1'b1; we = 1'b1; smp = 1'b0; adr = 8'hB6; din = 64'h123ababaabcdef90;
    model_clear();
    repeat (3) begin
      @(negedge clk);
      if (dut.bus_ack) acks++;
    end
    checks++;
    if (acks != 0 || dout !== '0 || dut.stb_q !== 1'b0 || dut.cyc_q !== 1'b0) begin
      failures++;
      $display("FAIL reset_state acks=%0d dout=%h stb=%b cyc=%b want 0", acks, dout, dut.stb_q, dut.cyc_q);
    end
    we = 1'b0;
    rst = 1'b0;
    do_txn(1'b0, 1'b1, 8'hB6, 64'h0, "read_after_reset");
  endtask

  task automatic test_held_write();
    logic [DATA_W-1:0] d = 64'h123ababaabcdef90;
    we = 1'b1; smp = 1'b0; adr = 8'hB6; din = d;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (dut.stb_q !== (k % 3 != 0) || dut.bus_ack !== (k % 3 == 2)) begin
        failures++;
        $display("FAIL held_write k=%0d stb=%b ack=%b want stb=%b ack=%b",
                 k, dut.stb_q, dut.bus_ack, (k % 3 != 0), (k % 3 == 2));
      end
    end
    we = 1'b0;
    model_txn(1'b1, 8'hB6, d);
  endtask

  task automatic test_busy_inputs();
    we = 1'b1; smp = 1'b0; adr = 8'hC6; din = 64'h1234567812345678;
    repeat (35) @(negedge clk);
    we = 1'b0;
    repeat (3) @(negedge clk);
    model_txn(1'b1, 8'hC6, 64'h1234567812345678);
    smp = 1'b1; adr = 8'hB6;
    @(negedge clk);
    din = 64'habcdefabcdefabcd; smp = 1'b0; adr = 8'h00;
    checks++;
    if (dout !== dout_m) begin
      failures++; $display("FAIL read_latency_early got=%h want=%h", dout, dout_m);
    end
    @(negedge clk);
    @(negedge clk);
    model_txn(1'b0, 8'hB6, '0);
    checks++;
    if (dout !== 64'h123ababaabcdef90 || dout !== dout_m) begin
      failures++; $display("FAIL read_busy_change got=%h want=%h", dout, dout_m);
    end
  endtask

  task automatic test_idle_hold();
    int stb_seen = 0;
    we = 1'b0; smp = 1'b0; adr = 8'hC6;
    repeat (10) begin
      @(negedge clk);
      if (dut.stb_q) stb_seen++;
    end
    checks++;
    if (stb_seen != 0 || dout !== dout_m) begin
      failures++; $display("FAIL idle_hold stb_cycles=%0d dout=%h want 0 and %h", stb_seen, dout, dout_m);
    end
    do_txn(1'b0, 1'b1, 8'hC6, 64'h0, "read_c6");
    checks++;
    if (dout !== 64'h1234567812345678) begin
      failures++; $display("FAIL read_c6_value got=%h want=1234567812345678", dout);
    end
  endtask

  task automatic test_default();
    do_txn(1'b0, 1'b1, 8'h06, 64'h0, "read_unmapped");
    do_txn(1'b1, 1'b0, 8'h46, 64'hdeadbeefdeadbeef, "write_unmapped");
    do_txn(1'b0, 1'b1, 8'hB6, 64'h0, "read_b6_unchanged");
    do_txn(1'b1, 1'b1, 8'hF6, 64'h0bad0bad0bad0bad, "write_wins");
    do_txn(1'b0, 1'b1, 8'hC6, 64'h0, "slv1_alias_word6");
  endtask

  task automatic test_reset_mid();
    we = 1'b1; smp = 1'b0; adr = 8'hC3; din = 64'hfeedfacecafef00d;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dut.stb_q !== 1'b0 || dut.cyc_q !== 1'b0 || dut.bus_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid stb=%b cyc=%b ack=%b want 0", dut.stb_q, dut.cyc_q, dut.bus_ack);
    end
    we = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    do_txn(1'b0, 1'b1, 8'hC3, 64'h0, "read_after_abort");
    do_txn(1'b0, 1'b1, 8'hB6, 64'h0, "storage_cleared");
  endtask

  task automatic test_random();
    logic [7:0]        a;
    logic [DATA_W-1:0] d;
    logic              w, s;
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = {1'b1, a[6:0]};
      d = {$urandom, $urandom};
      w = 1'($urandom_range(0, 1));
      s = w ? 1'($urandom_range(0, 1)) : 1'b1;
      do_txn(w, s, a, d, "random");
    end
  endtask

  initial begin
    test_reset();
    test_held_write();
    test_busy_inputs();
    test_idle_hold();
    test_default();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
